alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares a single combinational 3-bit-opcode ALU between two requesters (req0, req1) using round-robin arbitration.
- Latches the granted operation and holds the operands stable on the ALU ports for a fixed execution time: 1 cycle, or MUL_LAT cycles for multiply.
- Captures the result and returns it on a valid/ready response channel tagged with the requester id.
- Sits between the two issuing units and the shared ALU instance. Non-pipelined: one operation in flight.

Parameters:
- DATA_W, 32, operand/result width.
- MUL_LAT, 3, cycles spent in EXEC for op 3'b101 (multiply); legal range 1..15.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- req0_valid_i  input  1  requester 0 has an operation.
- req0_op_i  input  3  requester 0 ALU opcode.
- req0_src1_i  input  DATA_W  requester 0 operand 1.
- req0_src2_i  input  DATA_W  requester 0 operand 2.
- req0_ready_o  output  1  requester 0 operation accepted this cycle.
- req1_valid_i, req1_op_i, req1_src1_i, req1_src2_i, req1_ready_o  same as requester 0, for requester 1.
- alu_op_o  output  3  opcode to shared ALU.
- alu_src1_o  output  DATA_W  operand 1 to shared ALU.
- alu_src2_o  output  DATA_W  operand 2 to shared ALU.
- alu_result_i  input  DATA_W  combinational ALU result.
- resp_valid_o  output  1  response holds a result.
- resp_ready_i  input  1  consumer takes the response.
- resp_id_o  output  1  requester that issued the result.
- resp_result_o  output  DATA_W  captured ALU result.
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: state IDLE, prio 0, all outputs 0 (ready, resp_valid, resp_id, resp_result, alu_op, alu_src1/2, busy).
- Reset asserted mid-operation aborts the operation: no response is produced and no ready pulse occurs. The cycle after reset deasserts behaves as a fresh IDLE with prio 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant rules:
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant = prio.
- IDLE, on grant:
  - reqK_ready_o = 1 combinationally in the same cycle; the other ready = 0.
  - Latch op/src1/src2 into the operand registers that drive alu_*_o.
  - Latch id = K; set prio <= ~K.
  - Load cnt = MUL_LAT-1 if op == 3'b101, else 0.
  - Next state EXEC.
- IDLE, no valid: stay IDLE; readies 0; alu_*_o hold their last values.
- Readies are 0 in EXEC and RESP. A requester's valid/payload must stay stable until its ready is seen; the arbiter does not check this.
- EXEC:
  - alu_*_o stable.
  - If cnt == 0: resp_result <= alu_result_i, resp_id <= id, resp_valid <= 1, next state RESP.
  - Else: cnt <= cnt-1.
- RESP:
  - resp_valid_o = 1 with resp_id_o/resp_result_o stable until the cycle where resp_ready_i = 1.
  - In that cycle: resp_valid <= 0, next state IDLE.
  - Arbitration does not happen in the RESP cycle; the next grant is at earliest the following cycle.
- Latency, non-multiply: accept at cycle T, resp_valid_o high at T+2. Minimum issue interval is 3 cycles with resp_ready_i tied high.
- Latency, multiply: resp_valid_o high at T+1+MUL_LAT.
- No arithmetic is performed inside the block. The result is the ALU output sampled unmodified, DATA_W bits.
- Opcodes are passed through unchecked; all 8 codes are legal.
- prio is 1 bit and toggles only on grant, not on idle cycles. A lone requester is served back-to-back regardless of prio.

Test Plan:
- Reset, then req0 op=011 src1=5 src2=7 with ALU model → req0_ready pulse at T; resp_valid at T+2 with id=0, result=12.
- Both valid from the same cycle, resp_ready=1, three ops each → grant order 0,1,0,1,0,1; each ready pulse exactly one cycle.
- req1 op=101 src1=6 src2=7, MUL_LAT=3 → alu_* stable for 3 EXEC cycles; resp_valid at T+4 with id=1, result=42.
- resp_ready held 0 for 5 cycles → resp_valid/id/result stable; both readies 0 while req0/req1 valid; accept resumes the cycle after resp_ready=1.
- rst_i pulsed during EXEC of a multiply → no response; next cycle IDLE; both valid then grants req0 (prio reset to 0).
- Only req1 valid for 3 ops → all granted to req1; resp_id=1 each; busy_o low only in IDLE cycles.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for one shared combinational ALU: grants one of two requesters,
// holds the operands for the execution time and returns the captured result with its id.
module alu_rr_arbiter #(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid_i,
   input  logic [2:0]        req0_op_i,
   input  logic [DATA_W-1:0] req0_src1_i,
   input  logic [DATA_W-1:0] req0_src2_i,
   output logic              req0_ready_o,
   input  logic              req1_valid_i,
   input  logic [2:0]        req1_op_i,
   input  logic [DATA_W-1:0] req1_src1_i,
   input  logic [DATA_W-1:0] req1_src2_i,
   output logic              req1_ready_o,
   output logic [2:0]        alu_op_o,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [DATA_W-1:0] alu_src2_o,
   input  logic [DATA_W-1:0] alu_result_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic              resp_id_o,
   output logic [DATA_W-1:0] resp_result_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

   state_t              state_q, state_d;
   logic                prio_q, prio_d;
   logic                id_q, id_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [DATA_W-1:0]   src1_q, src1_d;
   logic [DATA_W-1:0]   src2_q, src2_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_id_q, resp_id_d;
   logic [DATA_W-1:0]   resp_result_q, resp_result_d;
   logic                grant_vld;
   logic                grant_id;
   logic                ready0, ready1;

   // Contention goes to prio; a lone requester wins regardless of prio.
   always_comb begin
      grant_vld = req0_valid_i | req1_valid_i;
      if (req0_valid_i && req1_valid_i) begin
         grant_id = prio_q;
      end else begin
         grant_id = req1_valid_i;
      end
   end

   always_comb begin
      state_d       = state_q;
      prio_d        = prio_q;
      id_d          = id_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      src1_d        = src1_q;
      src2_d        = src2_q;
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      ready0        = 1'b0;
      ready1        = 1'b0;
      case (state_q)
         IDLE: begin
            // No accept while reset is asserted, so a requester never sees a lost handshake.
            if (grant_vld && !rst_i) begin
               ready0 = ~grant_id;
               ready1 = grant_id;
               if (grant_id) begin
                  op_d   = req1_op_i;
                  src1_d = req1_src1_i;
                  src2_d = req1_src2_i;
               end else begin
                  op_d   = req0_op_i;
                  src1_d = req0_src1_i;
                  src2_d = req0_src2_i;
               end
               id_d    = grant_id;
               prio_d  = ~grant_id;
               cnt_d   = (op_d == OP_MUL) ? MUL_CNT : 4'd0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               resp_result_d = alu_result_i;
               resp_id_d     = id_q;
               resp_valid_d  = 1'b1;
               state_d       = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         prio_q        <= 1'b0;
         id_q          <= 1'b0;
         cnt_q         <= 4'd0;
         op_q          <= 3'd0;
         src1_q        <= '0;
         src2_q        <= '0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= 1'b0;
         resp_result_q <= '0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         id_q          <= id_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         src1_q        <= src1_d;
         src2_q        <= src2_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
      end
   end

   assign req0_ready_o  = ready0;
   assign req1_ready_o  = ready1;
   assign alu_op_o      = op_q;
   assign alu_src1_o    = src1_q;
   assign alu_src2_o    = src2_q;
   assign resp_valid_o  = resp_valid_q;
   assign resp_id_o     = resp_id_q;
   assign resp_result_o = resp_result_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-timestamp model of the arbiter.
module tb_alu_rr_arbiter;

   localparam int DATA_W  = 32;
   localparam int MUL_LAT = 3;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } op_t;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              req0_valid_i, req1_valid_i;
   logic [2:0]        req0_op_i, req1_op_i;
   logic [DATA_W-1:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
   logic              req0_ready_o, req1_ready_o;
   logic [2:0]        alu_op_o;
   logic [DATA_W-1:0] alu_src1_o, alu_src2_o, alu_result_i;
   logic              resp_valid_o, resp_ready_i, resp_id_o, busy_o;
   logic [DATA_W-1:0] resp_result_o;

   always #5 clk = ~clk;

   alu_rr_arbiter #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_op_i(req0_op_i), .req0_src1_i(req0_src1_i),
      .req0_src2_i(req0_src2_i), .req0_ready_o(req0_ready_o),
      .req1_valid_i(req1_valid_i), .req1_op_i(req1_op_i), .req1_src1_i(req1_src1_i),
      .req1_src2_i(req1_src2_i), .req1_ready_o(req1_ready_o),
      .alu_op_o(alu_op_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
      .alu_result_i(alu_result_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
      .resp_result_o(resp_result_o), .busy_o(busy_o)
   );

   function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return a + b;
         3'd4:    return a - b;
         3'd5:    return a * b;
         3'd6:    return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   assign alu_result_i = alu_ref(alu_op_o, alu_src1_o, alu_src2_o);

   int   total = 0;
   int   bad   = 0;
   op_t  q0[$];
   op_t  q1[$];
   logic v0 = 1'b0, v1 = 1'b0;
   logic acc0 = 1'b0, acc1 = 1'b0;
   int   pres_pct = 100;
   int   rr_mode  = 1;
   logic rnd_rst  = 1'b0;
   logic chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_rst) rst_i = ($urandom_range(0, 249) == 0);
      if (acc0 && v0) begin void'(q0.pop_front()); v0 = 1'b0; end
      if (acc1 && v1) begin void'(q1.pop_front()); v1 = 1'b0; end
      if (!v0 && q0.size() > 0 && $urandom_range(0, 99) < pres_pct) v0 = 1'b1;
      if (!v1 && q1.size() > 0 && $urandom_range(0, 99) < pres_pct) v1 = 1'b1;
      req0_valid_i = v0;
      req1_valid_i = v1;
      if (v0) begin
         req0_op_i = q0[0].op; req0_src1_i = q0[0].a; req0_src2_i = q0[0].b;
      end else begin
         req0_op_i = 3'($urandom); req0_src1_i = $urandom; req0_src2_i = $urandom;
      end
      if (v1) begin
         req1_op_i = q1[0].op; req1_src1_i = q1[0].a; req1_src2_i = q1[0].b;
      end else begin
         req1_op_i = 3'($urandom); req1_src1_i = $urandom; req1_src2_i = $urandom;
      end
      case (rr_mode)
         0:       resp_ready_i = 1'b0;
         1:       resp_ready_i = 1'b1;
         default: resp_ready_i = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic drain();
      logic done = 1'b0;
      rnd_rst  = 1'b0;
      rst_i    = 1'b0;
      rr_mode  = 1;
      pres_pct = 100;
      for (int i = 0; i < 200 && !done; i++) begin
         step();
         @(negedge clk);
         done = (q0.size() == 0 && q1.size() == 0 && !v0 && !v1 && busy_o === 1'b0);
      end
      chk("drain_done", 32'(done), 32'd1);
   endtask

   // Model: an accepted operation is described by when its response appears and what it holds.
   int          cyc = 0;
   logic        m_busy = 1'b0;
   logic        m_prio = 1'b0;
   int          m_resp_cyc = 0;
   logic        m_pend_id = 1'b0, m_id_last = 1'b0;
   logic [31:0] m_pend_res = '0, m_res_last = '0;
   logic [2:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0;

   initial begin
      logic e_r0, e_r1, e_rv, k, g;
      forever begin
         @(negedge clk);
         acc0 = (req0_ready_o === 1'b1);
         acc1 = (req1_ready_o === 1'b1);
         g = !rst_i && !m_busy && (req0_valid_i || req1_valid_i);
         k = (req0_valid_i && req1_valid_i) ? m_prio : req1_valid_i;
         e_r0 = g && !k;
         e_r1 = g && k;
         e_rv = m_busy && (cyc >= m_resp_cyc);
         if (chk_en) begin
            chk("req0_ready", 32'(req0_ready_o), 32'(e_r0));
            chk("req1_ready", 32'(req1_ready_o), 32'(e_r1));
            chk("busy", 32'(busy_o), 32'(m_busy));
            chk("resp_valid", 32'(resp_valid_o), 32'(e_rv));
            chk("resp_id", 32'(resp_id_o), 32'(e_rv ? m_pend_id : m_id_last));
            chk("resp_result", resp_result_o, e_rv ? m_pend_res : m_res_last);
            chk("alu_op", 32'(alu_op_o), 32'(m_op));
            chk("alu_src1", alu_src1_o, m_a);
            chk("alu_src2", alu_src2_o, m_b);
         end
         if (rst_i) begin
            m_busy = 1'b0; m_prio = 1'b0; m_op = '0; m_a = '0; m_b = '0;
            m_res_last = '0; m_id_last = 1'b0;
         end else if (g) begin
            m_op = k ? req1_op_i : req0_op_i;
            m_a  = k ? req1_src1_i : req0_src1_i;
            m_b  = k ? req1_src2_i : req0_src2_i;
            m_busy     = 1'b1;
            m_resp_cyc = cyc + 1 + ((m_op == 3'b101) ? MUL_LAT : 1);
            m_pend_res = alu_ref(m_op, m_a, m_b);
            m_pend_id  = k;
            m_prio     = ~k;
         end else if (e_rv && resp_ready_i) begin
            m_busy     = 1'b0;
            m_res_last = m_pend_res;
            m_id_last  = m_pend_id;
         end
         cyc++;
      end
   end

   initial begin
      rst_i = 1'b1; resp_ready_i = 1'b1;
      req0_valid_i = 1'b0; req0_op_i = '0; req0_src1_i = '0; req0_src2_i = '0;
      req1_valid_i = 1'b0; req1_op_i = '0; req1_src1_i = '0; req1_src2_i = '0;
      repeat (3) step();
      chk_en = 1'b1;
      rst_i  = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("rst_alu_op", 32'(alu_op_o), 32'd0);
      chk("rst_resp_result", resp_result_o, 32'd0);

      // req0 add 5+7: ready at T, response at T+2
      q0.push_back('{op: 3'd3, a: 32'd5, b: 32'd7});
      step(); @(negedge clk);
      chk("d1_ready0", 32'(req0_ready_o), 32'd1);
      step(); @(negedge clk);
      chk("d1_resp_valid_t1", 32'(resp_valid_o), 32'd0);
      step(); @(negedge clk);
      chk("d1_resp_valid_t2", 32'(resp_valid_o), 32'd1);
      chk("d1_resp_id", 32'(resp_id_o), 32'd0);
      chk("d1_resp_result", resp_result_o, 32'd12);
      step();

      // req1 multiply 6*7: operands held for MUL_LAT cycles, response at T+4
      q1.push_back('{op: 3'd5, a: 32'd6, b: 32'd7});
      step(); @(negedge clk);
      chk("d2_ready1", 32'(req1_ready_o), 32'd1);
      for (int i = 0; i < MUL_LAT; i++) begin
         step(); @(negedge clk);
         chk("d2_alu_op", 32'(alu_op_o), 32'd5);
         chk("d2_alu_src1", alu_src1_o, 32'd6);
         chk("d2_alu_src2", alu_src2_o, 32'd7);
         chk("d2_resp_valid_early", 32'(resp_valid_o), 32'd0);
      end
      step(); @(negedge clk);
      chk("d2_resp_valid", 32'(resp_valid_o), 32'd1);
      chk("d2_resp_id", 32'(resp_id_o), 32'd1);
      chk("d2_resp_result", resp_result_o, 32'd42);
      step();

      // Back-pressure: response held while both requesters wait
      rr_mode = 0;
      q0.push_back('{op: 3'd3, a: 32'd1, b: 32'd2});
      step(); @(negedge clk);
      chk("d3_ready0", 32'(req0_ready_o), 32'd1);
      q0.push_back('{op: 3'd4, a: 32'd9, b: 32'd2});
      q1.push_back('{op: 3'd1, a: 32'd4, b: 32'd8});
      step(); step();
      for (int i = 0; i < 5; i++) begin
         step(); @(negedge clk);
         chk("d3_hold_valid", 32'(resp_valid_o), 32'd1);
         chk("d3_hold_result", resp_result_o, 32'd3);
         chk("d3_hold_ready0", 32'(req0_ready_o), 32'd0);
         chk("d3_hold_ready1", 32'(req1_ready_o), 32'd0);
      end
      rr_mode = 1;
      step(); @(negedge clk);
      chk("d3_resp_cycle_ready1", 32'(req1_ready_o), 32'd0);
      step(); @(negedge clk);
      chk("d3_resume_ready1", 32'(req1_ready_o), 32'd1);
      drain();

      // Reset during a multiply aborts it; prio returns to requester 0
      q0.push_back('{op: 3'd5, a: 32'd3, b: 32'd4});
      step(); @(negedge clk);
      chk("d4_ready0", 32'(req0_ready_o), 32'd1);
      step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      @(negedge clk);
      chk("d4_busy", 32'(busy_o), 32'd0);
      chk("d4_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("d4_alu_op", 32'(alu_op_o), 32'd0);
      q0.push_back('{op: 3'd2, a: 32'hF0, b: 32'h0F});
      q1.push_back('{op: 3'd0, a: 32'hFF, b: 32'h3C});
      step(); @(negedge clk);
      chk("d4_ready0", 32'(req0_ready_o), 32'd1);
      chk("d4_ready1", 32'(req1_ready_o), 32'd0);
      drain();

      // Randomized traffic, back-pressure and occasional reset
      rr_mode = 2; pres_pct = 50; rnd_rst = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (q0.size() < 3 && $urandom_range(0, 3) == 0)
            q0.push_back('{op: 3'($urandom), a: $urandom, b: $urandom});
         if (q1.size() < 3 && $urandom_range(0, 3) == 0)
            q1.push_back('{op: 3'($urandom), a: $urandom, b: $urandom});
         step();
      end
      drain();

      // Lone requester 1 served back-to-back
      for (int i = 0; i < 3; i++)
         q1.push_back('{op: 3'($urandom_range(0, 7)), a: $urandom, b: $urandom});
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
